// File: rtl/axi_lite_slave_regs_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_ADDR, W_RESP} wr_state_e;
   typedef enum logic {R_ADDR, R_DATA} rd_state_e;

   function automatic logic [31:0] strb_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  strb
   );
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [ID_W-1:0]   awid;
   logic [3:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [ID_W-1:0]   wid;
   logic              wlast;
   logic [1:0]        bresp;
   logic [ID_W-1:0]   bid;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   arid;
   logic [3:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic [ID_W-1:0]   rid;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, awid, awlen, awsize, awburst,
      output wdata, wstrb, wvalid, wid, wlast, bready,
      output araddr, arvalid, arid, arlen, arsize, arburst, rready,
      input  awready, wready, bresp, bid, bvalid,
      input  arready, rdata, rresp, rid, rlast, rvalid
   );

   modport slave (
      input  awaddr, awvalid, awid, awlen, awsize, awburst,
      input  wdata, wstrb, wvalid, wid, wlast, bready,
      input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
      output awready, wready, bresp, bid, bvalid,
      output arready, rdata, rresp, rid, rlast, rvalid
   );
endinterface

// File: rtl/axi_lite_slave_regs_regfile.sv
// Register array: byte-strobed write port, combinational read port.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  logic [31:0]      wdata_i,
   input  logic [3:0]       wstrb_i,
   input  logic [IDX_W-1:0] ridx_i,
   output logic [31:0]      rdata_o
);
   logic [31:0] mem_q [NUM_REGS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[widx_i] <= strb_merge(mem_q[widx_i], wdata_i, wstrb_i);
      end
   end

   assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank with independent write and read engines.
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ID_W     = 4,
   parameter int NUM_REGS = 16
) (
   input logic         aclk,
   input logic         aresetn,
   axi_lite_if.slave   s
);
   localparam int IDX_W = $clog2(NUM_REGS);

   function automatic logic is_err(
      input logic [ADDR_W-1:0] a,
      input logic [3:0]        len
   );
      return (a >= ADDR_W'(NUM_REGS*4)) || (len != 4'd0);
   endfunction

   wr_state_e         wr_state_q, wr_state_d;
   rd_state_e         rd_state_q, rd_state_d;
   logic              rdy_q;
   logic              aw_held_q, aw_held_d;
   logic              w_held_q, w_held_d;
   logic              aw_err_q, aw_err_d;
   logic [IDX_W-1:0]  awidx_q, awidx_d;
   logic [ID_W-1:0]   awid_q, awid_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [ID_W-1:0]   bid_q, bid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic              awready, wready, arready;
   logic              aw_hs, w_hs, ar_hs;
   logic              we;
   logic              ar_err;
   logic [DATA_W-1:0] rf_rdata;
   logic              unused_ok;

   // Readies stay low until the first edge after reset release.
   assign awready = rdy_q && wr_state_q == W_ADDR && !aw_held_q;
   assign wready  = rdy_q && wr_state_q == W_ADDR && !w_held_q;
   assign arready = rdy_q && rd_state_q == R_ADDR;
   assign aw_hs   = s.awvalid && awready;
   assign w_hs    = s.wvalid && wready;
   assign ar_hs   = s.arvalid && arready;
   assign ar_err  = is_err(s.araddr, s.arlen);

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_err_d   = aw_err_q;
      awidx_d    = awidx_q;
      awid_d     = awid_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      bid_d      = bid_q;
      we         = 1'b0;
      unique case (wr_state_q)
         W_ADDR: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               aw_err_d  = is_err(s.awaddr, s.awlen);
               awidx_d   = s.awaddr[IDX_W+1:2];
               awid_d    = s.awid;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = s.wdata;
               wstrb_d  = s.wstrb;
            end
            if (aw_held_d && w_held_d) begin
               we         = !aw_err_d;
               bresp_d    = aw_err_d ? RESP_SLVERR : RESP_OKAY;
               bid_d      = awid_d;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s.bready) begin
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = W_ADDR;
            end
         end
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rid_d      = rid_q;
      unique case (rd_state_q)
         R_ADDR: begin
            if (ar_hs) begin
               rdata_d    = ar_err ? '0 : rf_rdata;
               rresp_d    = ar_err ? RESP_SLVERR : RESP_OKAY;
               rid_d      = s.arid;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s.rready) rd_state_d = R_ADDR;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_q <= W_ADDR;
         rd_state_q <= R_ADDR;
         rdy_q      <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_err_q   <= 1'b0;
         awidx_q    <= '0;
         awid_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= '0;
         bid_q      <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rid_q      <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         rdy_q      <= 1'b1;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_err_q   <= aw_err_d;
         awidx_q    <= awidx_d;
         awid_q     <= awid_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         bid_q      <= bid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rid_q      <= rid_d;
      end
   end

   axi_lite_regfile #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk_i   (aclk),
      .rst_ni  (aresetn),
      .we_i    (we),
      .widx_i  (awidx_d),
      .wdata_i (wdata_d),
      .wstrb_i (wstrb_d),
      .ridx_i  (s.araddr[IDX_W+1:2]),
      .rdata_o (rf_rdata)
   );

   assign s.awready = awready;
   assign s.wready  = wready;
   assign s.bvalid  = wr_state_q == W_RESP;
   assign s.bresp   = bresp_q;
   assign s.bid     = bid_q;
   assign s.arready = arready;
   assign s.rvalid  = rd_state_q == R_DATA;
   assign s.rlast   = rd_state_q == R_DATA;
   assign s.rdata   = rdata_q;
   assign s.rresp   = rresp_q;
   assign s.rid     = rid_q;

   assign unused_ok = ^{s.awsize, s.awburst, s.wid, s.wlast,
                        s.arsize, s.arburst};
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for the AXI4-Lite register slave.
module tb_axi_lite_slave_regs;
   import axi_lite_pkg::*;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 aclk = ~aclk;

   axi_lite_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

   axi_lite_slave_regs #(
      .ADDR_W(32), .DATA_W(32), .ID_W(4), .NUM_REGS(16)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s       (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.awaddr = '0; bus.awvalid = 0; bus.awid = '0; bus.awlen = '0;
      bus.awsize = 3'd2; bus.awburst = 2'd1;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
      bus.wid = '0; bus.wlast = 1; bus.bready = 0;
      bus.araddr = '0; bus.arvalid = 0; bus.arid = '0; bus.arlen = '0;
      bus.arsize = 3'd2; bus.arburst = 2'd1; bus.rready = 0;
   endtask

   task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] st, input logic [3:0] id,
                         input logic [3:0] len, input int aw_dly,
                         output logic [1:0] resp, output logic [3:0] bid,
                         output int lat);
      logic aw_done, w_done, awg, wg;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      bus.awaddr = a; bus.awid = id; bus.awlen = len;
      bus.wdata = d; bus.wstrb = st;
      bus.wvalid = 1; bus.awvalid = (aw_dly == 0);
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge aclk);
         awg = bus.awvalid && bus.awready;
         wg  = bus.wvalid && bus.wready;
         @(posedge aclk); #1;
         n++;
         if (awg) begin aw_done = 1; bus.awvalid = 0; end
         if (wg)  begin w_done = 1;  bus.wvalid = 0; end
         if (!aw_done && n >= aw_dly) bus.awvalid = 1;
      end
      if (n >= 50) chk("aw_w_timeout", 32'd1, 32'd0);
      bus.awvalid = 0; bus.wvalid = 0;
      bus.bready = 1;
      lat = 0;
      @(negedge aclk);
      while (!bus.bvalid && lat < 50) begin @(negedge aclk); lat++; end
      resp = bus.bresp; bid = bus.bid;
      @(posedge aclk); #1;
      bus.bready = 0;
   endtask

   task automatic axi_rd(input logic [31:0] a, input logic [3:0] id,
                         input logic [3:0] len, output logic [31:0] d,
                         output logic [1:0] resp, output logic [3:0] rid,
                         output logic last, output int lat);
      int n;
      n = 0;
      bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arvalid = 1;
      @(negedge aclk);
      while (!bus.arready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) chk("ar_timeout", 32'd1, 32'd0);
      @(posedge aclk); #1;
      bus.arvalid = 0; bus.rready = 1;
      lat = 0;
      @(negedge aclk);
      while (!bus.rvalid && lat < 50) begin @(negedge aclk); lat++; end
      d = bus.rdata; resp = bus.rresp; rid = bus.rid; last = bus.rlast;
      @(posedge aclk); #1;
      bus.rready = 0;
   endtask

   logic [1:0]  resp;
   logic [3:0]  id;
   logic [31:0] d;
   logic        last;
   int          lat;

   initial begin
      bus_idle();
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_awready", 32'(bus.awready), 0);
      chk("rst_wready",  32'(bus.wready),  0);
      chk("rst_arready", 32'(bus.arready), 0);
      chk("rst_bvalid",  32'(bus.bvalid),  0);
      chk("rst_rvalid",  32'(bus.rvalid),  0);
      chk("rst_rdata",   bus.rdata,        0);
      @(posedge aclk); #1;
      aresetn = 1;
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("rdy_aw_w_ar", {29'd0, bus.awready, bus.wready, bus.arready}, 7);
      @(posedge aclk); #1;

      // basic write/read
      axi_wr(32'h8, 32'hDEADBEEF, 4'hF, 4'h5, 0, 0, resp, id, lat);
      chk("t1_bresp", 32'(resp), 0);
      chk("t1_bid",   32'(id),   5);
      chk("t1_blat",  32'(lat),  0);
      axi_rd(32'h8, 4'h3, 0, d, resp, id, last, lat);
      chk("t1_rdata", d, 32'hDEADBEEF);
      chk("t1_rresp", 32'(resp), 0);
      chk("t1_rid",   32'(id),   3);
      chk("t1_rlast", 32'(last), 1);
      chk("t1_rlat",  32'(lat),  0);

      // W leads AW by three cycles, partial strobe
      axi_wr(32'h8, 32'h12345678, 4'b0011, 4'h6, 0, 3, resp, id, lat);
      chk("t2_bresp", 32'(resp), 0);
      chk("t2_bid",   32'(id),   6);
      chk("t2_blat",  32'(lat),  0);
      axi_rd(32'h8, 4'h1, 0, d, resp, id, last, lat);
      chk("t2_rdata", d, 32'hDEAD5678);

      // out-of-range address
      axi_wr(32'h40, 32'hFFFFFFFF, 4'hF, 4'h7, 0, 0, resp, id, lat);
      chk("t3_bresp", 32'(resp), 2);
      axi_rd(32'h40, 4'h2, 0, d, resp, id, last, lat);
      chk("t3_rdata", d, 0);
      chk("t3_rresp", 32'(resp), 2);
      axi_rd(32'h0, 4'h2, 0, d, resp, id, last, lat);
      chk("t3_reg0",  d, 0);

      // burst length not zero
      axi_wr(32'h4, 32'hAAAAAAAA, 4'hF, 4'h8, 3, 0, resp, id, lat);
      chk("t4_bresp", 32'(resp), 2);
      axi_rd(32'h4, 4'h2, 0, d, resp, id, last, lat);
      chk("t4_reg1",  d, 0);
      axi_rd(32'h8, 4'h2, 3, d, resp, id, last, lat);
      chk("t4_arlen_rresp", 32'(resp), 2);
      chk("t4_arlen_rdata", d, 0);

      // zero strobe is OKAY with no change
      axi_wr(32'h8, 32'h00000000, 4'h0, 4'h4, 0, 0, resp, id, lat);
      chk("t4b_bresp", 32'(resp), 0);
      axi_rd(32'h8, 4'h2, 0, d, resp, id, last, lat);
      chk("t4b_rdata", d, 32'hDEAD5678);

      // B back-pressure
      bus.awaddr = 32'hC; bus.awid = 4'h9; bus.awlen = 0;
      bus.wdata = 32'h0000C0DE; bus.wstrb = 4'hF;
      bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
      @(negedge aclk);
      chk("t5_hs", {30'd0, bus.awready, bus.wready}, 3);
      @(posedge aclk); #1;
      bus.awid = 4'hA; bus.wdata = 32'hCAFE0000; bus.wstrb = 4'b1100;
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         chk("t5_hold", {23'd0, bus.bvalid, bus.bid, bus.bresp,
                         bus.awready, bus.wready}, {23'd0, 1'b1, 4'h9, 4'b0000});
         @(posedge aclk); #1;
      end
      bus.bready = 1;
      @(posedge aclk); #1;
      bus.bready = 0;
      @(negedge aclk);
      chk("t5_next_rdy", {30'd0, bus.awready, bus.wready}, 3);
      @(posedge aclk); #1;
      bus.awvalid = 0; bus.wvalid = 0; bus.bready = 1;
      @(negedge aclk);
      chk("t5_b2", {27'd0, bus.bvalid, bus.bid}, {27'd0, 1'b1, 4'hA});
      @(posedge aclk); #1;
      bus.bready = 0;
      axi_rd(32'hC, 4'h2, 0, d, resp, id, last, lat);
      chk("t5_rdata", d, 32'hCAFEC0DE);

      // same-cycle commit and read of register 0
      axi_wr(32'h0, 32'h11111111, 4'hF, 4'h1, 0, 0, resp, id, lat);
      bus.awaddr = 32'h0; bus.awid = 4'h1; bus.awlen = 0;
      bus.wdata = 32'h22222222; bus.wstrb = 4'hF;
      bus.araddr = 32'h0; bus.arid = 4'h2; bus.arlen = 0;
      bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
      @(negedge aclk);
      chk("t6_rdy", {29'd0, bus.awready, bus.wready, bus.arready}, 7);
      @(posedge aclk); #1;
      bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
      bus.rready = 1; bus.bready = 1;
      @(negedge aclk);
      chk("t6_vld", {30'd0, bus.rvalid, bus.bvalid}, 3);
      chk("t6_old", bus.rdata, 32'h11111111);
      @(posedge aclk); #1;
      bus.rready = 0; bus.bready = 0;
      axi_rd(32'h0, 4'h2, 0, d, resp, id, last, lat);
      chk("t6_new", d, 32'h22222222);

      // reset while a read response is pending
      bus.araddr = 32'h8; bus.arvalid = 1;
      @(negedge aclk);
      @(posedge aclk); #1;
      bus.arvalid = 0;
      @(negedge aclk);
      chk("t7_rvalid_pre", 32'(bus.rvalid), 1);
      #1 aresetn = 0;
      #1;
      chk("t7_rvalid_rst", 32'(bus.rvalid), 0);
      chk("t7_rdata_rst",  bus.rdata, 0);
      @(posedge aclk); #1;
      aresetn = 1;
      @(posedge aclk); #1;
      axi_rd(32'h0, 4'h2, 0, d, resp, id, last, lat);
      chk("t7_reg0", d, 0);
      axi_rd(32'h8, 4'h2, 0, d, resp, id, last, lat);
      chk("t7_reg2", d, 0);
      axi_rd(32'hC, 4'h2, 0, d, resp, id, last, lat);
      chk("t7_reg3", d, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
